intc_ext: RTL and testbench

Parametrised interrupt controller that collects up to 16 asynchronous interrupt sources and presents them to the CSR bus as banks of 8-bit registers. It drives a single registered interrupt line toward the host. Compared with the first-generation controller, it adds:
- input synchronisers,
- per-source edge/level mode and polarity,
- multi-bank addressing,
- an optional priority vector register.

---
 rtl/intc_pkg.sv | 13 +
 rtl/intc_src.sv | 25 ++
 rtl/intc_ext.sv | 94 +++++++++
 tb/tb_intc_ext.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// intc_pkg: shared register offsets, limits and bank arithmetic for the intc_ext controller
package intc_pkg;
    localparam int REG_IE = 0;
    localparam int REG_IP = 1;
    localparam int REG_MODE = 2;
    localparam int REG_POL = 3;
    localparam int REG_STRIDE = 4;
    localparam int VEC_VALID_BIT = 7;
    localparam int INTC_MAX_INTS = 16;
    function automatic int bank_count(input int num_ints);
        return (num_ints + 7) / 8;
    endfunction
endpackage

// File: rtl/intc_src.sv
// intc_src: per-source synchroniser, polarity normalisation and edge/level set request
module intc_src #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_raw,
    input  logic pol,
    input  logic mode,
    output logic set_req
);
    logic [SYNC_STAGES-1:0] sync;
    logic s, s_d;
    assign s = sync[SYNC_STAGES-1] ^ pol;
    assign set_req = mode ? s & ~s_d : s;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            s_d <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], irq_raw};
            s_d <= s;
        end
    end
endmodule

// File: rtl/intc_ext.sv
// intc_ext: banked CSR interrupt controller with synchronised edge/level sources and a registered irq.
// Defining INTC_VECTOR_EN adds the read-only VEC priority register after the last bank.
module intc_ext
    import intc_pkg::*;
#(
    parameter logic [4:0] BASE_ADDR = 5'h0,
    parameter int NUM_INTS = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          csr_a,
    input  logic [7:0]          csr_di,
    input  logic                csr_we,
    output logic [7:0]          csr_do,
    input  logic [NUM_INTS-1:0] irqs_in,
    output logic                irq
);
    localparam int NB = bank_count(NUM_INTS);
    localparam int W = NB * 8;
    localparam logic [W-1:0] VALID = W'((64'd1 << NUM_INTS) - 64'd1);
    logic [W-1:0] ie, ip, mode, pol, set_w, wsel, wdata, pend;
    logic [NUM_INTS-1:0] set_req;
    logic [4:0] off;
    logic [2:0] bank;
    logic [1:0] rsel;
    logic reg_hit, reg_wr;
    genvar i;
    for (i = 0; i < NUM_INTS; i++) begin : g_src
        intc_src #(.SYNC_STAGES(SYNC_STAGES)) u_src (
            .clk(clk),
            .rst(rst),
            .irq_raw(irqs_in[i]),
            .pol(pol[i]),
            .mode(mode[i]),
            .set_req(set_req[i])
        );
    end
    assign set_w = W'(set_req);
    assign pend = ie & ip;
    assign off = csr_a - BASE_ADDR;
    assign bank = off[4:2];
    assign rsel = off[1:0];
    assign reg_hit = csr_a >= BASE_ADDR && off < 5'(REG_STRIDE * NB);
    assign reg_wr = csr_we && reg_hit;
    assign wdata = {NB{csr_di}};
    // Byte lane of the addressed bank, trimmed to implemented sources
    always_comb begin
        wsel = '0;
        for (int b = 0; b < NB; b++)
            if (bank == 3'(b)) wsel[8*b +: 8] = 8'hFF;
        wsel = wsel & VALID;
    end
`ifdef INTC_VECTOR_EN
    logic [7:0] vec;
    logic is_vec;
    assign is_vec = csr_a >= BASE_ADDR && off == 5'(REG_STRIDE * NB);
    always_comb begin
        vec = 8'h00;
        for (int j = NUM_INTS - 1; j >= 0; j--)
            if (pend[j]) begin
                vec = 8'(j);
                vec[VEC_VALID_BIT] = 1'b1;
            end
    end
`endif
    always_comb begin
        csr_do = 8'h00;
        for (int b = 0; b < NB; b++)
            if (reg_hit && bank == 3'(b))
                csr_do = rsel == 2'(REG_IE) ? ie[8*b +: 8] :
                         rsel == 2'(REG_IP) ? ip[8*b +: 8] :
                         rsel == 2'(REG_MODE) ? mode[8*b +: 8] : pol[8*b +: 8];
`ifdef INTC_VECTOR_EN
        if (is_vec) csr_do = vec;
`endif
    end
    // Set is OR-ed after the W1C mask so a colliding event is never lost
    always_ff @(posedge clk) begin
        if (rst) begin
            ie <= '0;
            ip <= '0;
            mode <= '0;
            pol <= '0;
            irq <= 1'b0;
        end else begin
            if (reg_wr && rsel == 2'(REG_IE)) ie <= (ie & ~wsel) | (wdata & wsel);
            if (reg_wr && rsel == 2'(REG_MODE)) mode <= (mode & ~wsel) | (wdata & wsel);
            if (reg_wr && rsel == 2'(REG_POL)) pol <= (pol & ~wsel) | (wdata & wsel);
            ip <= (ip & ~(reg_wr && rsel == 2'(REG_IP) ? wdata & wsel : '0)) | (set_w & VALID);
            irq <= |pend;
        end
    end
endmodule

// File: tb/tb_intc_ext.sv
// tb_intc_ext: vector table, directed corner sequences and a randomized model comparison for intc_ext
module tb_intc_ext;
    localparam int SYNC = 2;
    logic clk = 1'b0, rst = 1'b1;
    logic [4:0] csr_a = '0, s_a = '0;
    logic [7:0] csr_di = '0, s_di = '0, csr_do, s_do;
    logic csr_we = 1'b0, s_we = 1'b0, irq, s_irq;
    logic [15:0] irqs = '0;
    logic [4:0] s_irqs = '0;
    int n_tests = 0, n_fail = 0;

    intc_ext #(.BASE_ADDR(5'h0), .NUM_INTS(16), .SYNC_STAGES(SYNC)) u_dut (
        .clk(clk), .rst(rst), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
        .csr_do(csr_do), .irqs_in(irqs), .irq(irq)
    );
    intc_ext #(.BASE_ADDR(5'h10), .NUM_INTS(5), .SYNC_STAGES(3)) u_small (
        .clk(clk), .rst(rst), .csr_a(s_a), .csr_di(s_di), .csr_we(s_we),
        .csr_do(s_do), .irqs_in(s_irqs), .irq(s_irq)
    );

    always #50 clk = ~clk;

`ifdef INTC_VECTOR_EN
    localparam bit VEC_ON = 1'b1;
`else
    localparam bit VEC_ON = 1'b0;
`endif

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic rd(input string nm, input logic [4:0] a, input logic [7:0] exp);
        csr_a = a;
        #1 chk(nm, csr_do, exp);
    endtask
    task automatic srd(input string nm, input logic [4:0] a, input logic [7:0] exp);
        s_a = a;
        #1 chk(nm, s_do, exp);
    endtask
    task automatic chk_irq(input string nm, input logic exp);
        chk(nm, {7'b0, irq}, {7'b0, exp});
    endtask
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        csr_a = a; csr_di = d; csr_we = 1'b1;
        @(negedge clk);
        csr_we = 1'b0;
    endtask
    task automatic swr(input logic [4:0] a, input logic [7:0] d);
        s_a = a; s_di = d; s_we = 1'b1;
        @(negedge clk);
        s_we = 1'b0;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    // Reference model: raw inputs reach the source logic SYNC edges after sampling
    logic [15:0] m_ie, m_ip, m_mode, m_pol, m_sd;
    logic m_irq;
    logic [15:0] hist[$];
    task automatic model_reset();
        m_ie = '0; m_ip = '0; m_mode = '0; m_pol = '0; m_sd = '0; m_irq = 1'b0;
        hist = {};
        repeat (SYNC) hist.push_back(16'h0);
    endtask
    task automatic model_edge(input logic we, input int a, input logic [7:0] d, input logic [15:0] raw);
        logic [15:0] s, set, clr, dd;
        s = hist[0] ^ m_pol;
        set = (m_mode & s & ~m_sd) | (~m_mode & s);
        dd = {d, d};
        clr = '0;
        m_irq = |(m_ie & m_ip);
        if (we && a < 8) begin
            logic [15:0] lane;
            lane = (a / 4 == 0) ? 16'h00FF : 16'hFF00;
            case (a % 4)
                0: m_ie = (m_ie & ~lane) | (dd & lane);
                1: clr = dd & lane;
                2: m_mode = (m_mode & ~lane) | (dd & lane);
                default: m_pol = (m_pol & ~lane) | (dd & lane);
            endcase
        end
        m_ip = (m_ip & ~clr) | set;
        m_sd = s;
        void'(hist.pop_front());
        hist.push_back(raw);
    endtask
    function automatic logic [7:0] m_rd(input int a);
        logic [15:0] p;
        p = m_ie & m_ip;
        if (a < 8) begin
            logic [15:0] r;
            r = (a % 4 == 0) ? m_ie : (a % 4 == 1) ? m_ip : (a % 4 == 2) ? m_mode : m_pol;
            return a / 4 == 0 ? r[7:0] : r[15:8];
        end
        if (a == 8 && VEC_ON)
            for (int j = 0; j < 16; j++)
                if (p[j]) return 8'h80 + 8'(j);
        return 8'h00;
    endfunction

    typedef struct {
        logic [15:0] src;
        logic [15:0] en;
        logic [7:0] vec;
        logic irq;
    } vec_t;
    vec_t tv[7];

    initial begin
        tv[0] = '{16'h1020, 16'hFFFF, 8'h85, 1'b1};
        tv[1] = '{16'h1000, 16'hFFFF, 8'h8C, 1'b1};
        tv[2] = '{16'h0021, 16'h0020, 8'h85, 1'b1};
        tv[3] = '{16'h8000, 16'h8000, 8'h8F, 1'b1};
        tv[4] = '{16'h00F0, 16'h0000, 8'h00, 1'b0};
        tv[5] = '{16'h0000, 16'hFFFF, 8'h00, 1'b0};
        tv[6] = '{16'hFFFF, 16'h0100, 8'h88, 1'b1};
        cyc(2);
        rst = 1'b0;
        for (int a = 0; a < 32; a++) rd("reset_rd", 5'(a), 8'h00);
        chk_irq("reset_irq", 1'b0);
        for (int a = 16; a < 21; a++) srd("small_reset_rd", 5'(a), 8'h00);
        chk("small_reset_irq", {7'b0, s_irq}, 8'h00);

        // Level-mode priority table
        for (int t = 0; t < 7; t++) begin
            irqs = '0;
            do_reset();
            wr(5'd0, tv[t].en[7:0]);
            wr(5'd4, tv[t].en[15:8]);
            irqs = tv[t].src;
            cyc(4);
            rd("tbl_ip0", 5'd1, tv[t].src[7:0]);
            rd("tbl_ip1", 5'd5, tv[t].src[15:8]);
            chk_irq("tbl_irq", tv[t].irq);
            rd("tbl_vec", 5'd8, VEC_ON ? tv[t].vec : 8'h00);
        end

        // Edge rising on source 10: latency and W1C
        irqs = '0;
        do_reset();
        wr(5'd4, 8'h04);
        wr(5'd6, 8'h04);
        irqs[10] = 1'b1;
        cyc(2);
        rd("edge_ip_k1", 5'd5, 8'h00);
        cyc(1);
        rd("edge_ip_k2", 5'd5, 8'h04);
        chk_irq("edge_irq_k2", 1'b0);
        cyc(1);
        chk_irq("edge_irq_k3", 1'b1);
        rd("edge_vec", 5'd8, VEC_ON ? 8'h8A : 8'h00);
        wr(5'd5, 8'h04);
        rd("edge_w1c_ip", 5'd5, 8'h00);
        chk_irq("edge_w1c_irq_m", 1'b1);
        cyc(1);
        chk_irq("edge_w1c_irq_m1", 1'b0);
        cyc(3);
        rd("edge_held_ip", 5'd5, 8'h00);

        // Level active-low on source 0
        irqs = '0;
        do_reset();
        wr(5'd3, 8'h01);
        wr(5'd0, 8'h01);
        cyc(3);
        rd("lvl_ip", 5'd1, 8'h01);
        chk_irq("lvl_irq", 1'b1);
        wr(5'd1, 8'h01);
        rd("lvl_w1c_active", 5'd1, 8'h01);
        irqs[0] = 1'b1;
        cyc(4);
        rd("lvl_released_ip", 5'd1, 8'h01);
        wr(5'd1, 8'h01);
        rd("lvl_w1c_ip", 5'd1, 8'h00);
        cyc(1);
        chk_irq("lvl_irq_drop", 1'b0);

        // Set and W1C on the same edge for source 3
        irqs = '0;
        do_reset();
        wr(5'd2, 8'h08);
        irqs[3] = 1'b1;
        cyc(2);
        wr(5'd1, 8'h08);
        rd("collide_ip", 5'd1, 8'h08);
        cyc(1);
        rd("collide_ip_hold", 5'd1, 8'h08);
        wr(5'd1, 8'h08);
        rd("collide_cleared", 5'd1, 8'h00);

        // Masking with IE
        irqs = '0;
        do_reset();
        irqs = 16'h0004;
        cyc(4);
        rd("mask_ip", 5'd1, 8'h04);
        chk_irq("mask_irq_off", 1'b0);
        wr(5'd0, 8'h04);
        chk_irq("mask_irq_m", 1'b0);
        cyc(1);
        chk_irq("mask_irq_on", 1'b1);
        wr(5'd0, 8'h00);
        chk_irq("unmask_irq_m", 1'b1);
        cyc(1);
        chk_irq("unmask_irq_off", 1'b0);

        // Five-source instance at base 0x10 with three sync stages
        swr(5'h10, 8'hFF);
        srd("small_ie_bits", 5'h10, 8'h1F);
        swr(5'h12, 8'hFF);
        srd("small_mode_bits", 5'h12, 8'h1F);
        swr(5'h12, 8'h00);
        s_irqs = 5'h1F;
        cyc(3);
        srd("small_ip_k2", 5'h11, 8'h00);
        cyc(1);
        srd("small_ip_k3", 5'h11, 8'h1F);
        cyc(1);
        chk("small_irq", {7'b0, s_irq}, 8'h01);
        srd("small_vec", 5'h14, VEC_ON ? 8'h80 : 8'h00);
        srd("small_unmapped_hi", 5'h15, 8'h00);
        srd("small_unmapped_lo", 5'h0F, 8'h00);
        swr(5'h11, 8'hFF);
        srd("small_w1c_level", 5'h11, 8'h1F);

        // Randomized run against the model, including mid-run resets
        irqs = '0;
        do_reset();
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            int a;
            logic we;
            logic [7:0] d;
            for (int k = 0; k < 32; k++) rd("rnd_rd", 5'(k), m_rd(k));
            chk_irq("rnd_irq", m_irq);
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) irqs = irqs ^ 16'(1 << $urandom_range(0, 15));
            we = 1'($urandom_range(0, 1));
            a = $urandom_range(0, 1) ? $urandom_range(0, 8) : $urandom_range(0, 31);
            d = 8'($urandom);
            csr_a = 5'(a); csr_di = d; csr_we = we;
            if (rst) model_reset();
            else model_edge(we, a, d, irqs);
            @(negedge clk);
            csr_we = 1'b0;
            rst = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
